// File: rtl/vram_write_scheduler.sv
// Arbitrates the single-port VRAM between scan-out reads and queued game writes.
// Writes drain from a small FIFO only in blanking slots clear of the read guard.
module vram_write_scheduler #(
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 8,
   parameter int HD         = 640,
   parameter int HT         = 800,
   parameter int VD         = 480,
   parameter int VT         = 525,
   parameter int GUARD      = 2
) (
   input  logic                          pclk,
   input  logic                          reset,
   input  logic [9:0]                    pixel_cnt,
   input  logic [9:0]                    line_cnt,
   input  logic [ADDR_W-1:0]             disp_addr,
   input  logic                          vblank_only,
   input  logic                          wr_valid,
   input  logic [ADDR_W-1:0]             wr_addr,
   input  logic [DATA_W-1:0]             wr_data,
   output logic                          wr_ready,
   output logic                          ram_we,
   output logic [ADDR_W-1:0]             ram_addr,
   output logic [DATA_W-1:0]             ram_din,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          busy,
   output logic [15:0]                   frame_writes
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   logic [ADDR_W+DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]            rd_ptr;
   logic [PW-1:0]            wr_ptr;
   logic [ADDR_W-1:0]        head_addr;
   logic [DATA_W-1:0]        head_data;
   logic                     mode_q;
   logic [15:0]              wcnt;
   logic [15:0]              wcnt_nx;
   logic                     frame_end;
   logic                     next_active;
   logic                     guard_zone;
   logic                     slot_ok;
   logic                     wr_slot;
   logic                     push;

   assign frame_end = (line_cnt == 10'(VT - 1)) &&
                      (pixel_cnt == 10'(HT - 1));

   // The line following the current one is visible (wraps at frame end).
   assign next_active = (({1'b0, line_cnt} + 11'd1) < 11'(VD)) ||
                        (line_cnt == 10'(VT - 1));

   assign guard_zone = next_active &&
                       (pixel_cnt >= 10'(HT - GUARD));

   always_comb begin
      slot_ok = 1'b0;
      if (mode_q)
         slot_ok = (line_cnt >= 10'(VD)) && !guard_zone;
      else
         slot_ok = ((line_cnt >= 10'(VD)) ||
                    (pixel_cnt >= 10'(HD))) && !guard_zone;
   end

   assign wr_slot  = slot_ok && (fifo_level != '0);
   assign wr_ready = !reset && (fifo_level < LW'(FIFO_DEPTH));
   assign push     = wr_valid && wr_ready;
   assign busy     = (fifo_level != '0);

   assign {head_addr, head_data} = mem[rd_ptr];

   assign ram_we   = wr_slot;
   assign ram_addr = wr_slot ? head_addr : disp_addr;
   assign ram_din  = head_data;

   assign wcnt_nx = (wr_slot && (wcnt != 16'hFFFF)) ? wcnt + 16'd1 : wcnt;

   always_ff @(posedge pclk) begin
      if (push)
         mem[wr_ptr] <= {wr_addr, wr_data};
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         fifo_level   <= '0;
         mode_q       <= 1'b0;
         wcnt         <= '0;
         frame_writes <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (wr_slot)
            rd_ptr <= rd_ptr + 1'b1;
         fifo_level <= fifo_level + LW'(push) - LW'(wr_slot);
         // Mode and statistics roll over only at the frame boundary.
         if (frame_end) begin
            mode_q       <= vblank_only;
            frame_writes <= wcnt_nx;
            wcnt         <= '0;
         end else begin
            wcnt <= wcnt_nx;
         end
      end
   end

endmodule

// File: doc/vram_write_scheduler.md
Name: vram_write_scheduler

Overview:
- Shares the single-port tile/pixel block RAM between display scan-out and a game-logic write requester.
- Scan-out is the timing master and is never stalled.
- Writes are accepted through a valid/ready handshake into a small FIFO and drained into the RAM only in blanking slots.
- Sits between the VGA timing controller (raw pixel/line counters), the scan-out address logic and the RAM port.

Parameters:
- ADDR_W, 13, RAM address width
- DATA_W, 12, RAM data width (RGB444)
- FIFO_DEPTH, 8, write FIFO entries (power of two, >=2)
- HD, 640, active pixels per line
- HT, 800, total pixels per line
- VD, 480, active lines
- VT, 525, total lines
- GUARD, 2, cycles before the next active pixel in which writes are forbidden (covers 1-cycle RAM read latency plus margin)

Ports:
- pclk  in  1  pixel clock, 25 MHz
- reset  in  1  synchronous, active-high
- pixel_cnt  in  10  raw horizontal counter, 0..HT-1
- line_cnt  in  10  raw vertical counter, 0..VT-1
- disp_addr  in  ADDR_W  scan-out read address
- vblank_only  in  1  1 = drain only in vertical blank (tear-free); sampled per frame
- wr_valid  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ready  out  1  FIFO can accept
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- fifo_level  out  log2(FIFO_DEPTH)+1  entries held
- busy  out  1  fifo_level != 0
- frame_writes  out  16  writes committed in the previous frame

Behaviour:
- Clock and reset: clock pclk; reset is synchronous, active-high.
- Reset values:
  - FIFO emptied; fifo_level=0, busy=0.
  - wr_ready=0 while reset is high, 1 on the first cycle after.
  - ram_we=0; mode_q=0; frame_writes=0; internal write counter=0.
- Reset mid-drain: any un-committed FIFO contents are discarded.
- Frame boundary: frame_end = (line_cnt==VT-1 && pixel_cnt==HT-1). On frame_end:
  - mode_q <= vblank_only;
  - frame_writes <= internal counter, with that cycle's commit included;
  - internal counter <= 0.
  - Mode changes never take effect mid-frame.
- next_active = (line_cnt+1 < VD) || (line_cnt==VT-1). The line after the current one is visible.
- guard_zone = next_active && pixel_cnt >= HT-GUARD.
- slot_ok:
  - mode_q=0: (line_cnt>=VD || pixel_cnt>=HD) && !guard_zone.
  - mode_q=1: line_cnt>=VD && !guard_zone.
- wr_slot = slot_ok && fifo_level!=0. This is combinational from the counters and registered state.
- RAM port mux (combinational):
  - wr_slot=1: ram_we=1, ram_addr/ram_din = FIFO head; head pops at the clock edge.
  - wr_slot=0: ram_we=0, ram_addr=disp_addr, ram_din=FIFO head (don't-care).
  - The display therefore owns the port on every active pixel and on every guard cycle.
- FIFO behaviour:
  - Push when wr_valid && wr_ready; wr_ready = (fifo_level < FIFO_DEPTH).
  - Full: wr_ready=0 even if a pop occurs the same cycle. No full bypass.
  - Empty: a push is not bypassed to the RAM; the earliest commit is the next cycle with slot_ok.
  - Simultaneous push and pop: fifo_level unchanged.
  - Commits preserve acceptance order. Same-address writes: the last accepted wins.
- Internal write counter increments per commit and saturates at 16'hFFFF.
- Latency: accept-to-commit >= 1 cycle; bounded by the next slot_ok window.

Test Plan:
1. Reset held 3 cycles, wr_valid=1 -> wr_ready=0, ram_we=0, fifo_level=0 during reset; wr_ready=1 on the first cycle after release.
2. mode 0, line 100, push 3 writes (addr 5,6,7; data 12'hF00,12'h0F0,12'h00F) at pixel 600 -> ram_we=1 at pixels 640,641,642 in order; ram_addr=disp_addr on pixels 600..639.
3. mode 0, line 100, FIFO holding 4 entries from pixel 797 -> no ram_we at pixels 798,799 (guard); draining resumes at pixel 640 of line 101.
4. Push 9 back-to-back writes during active video, DEPTH=8 -> wr_ready=0 after 8 accepted; fifo_level=8; the 9th is held by the requester until the first drain.
5. vblank_only=1 applied mid-frame -> mode 0 slots still used until frame_end; next frame writes occur only on lines 480..524, with none at line 524 pixels 798..799.
6. 10 writes committed in frame N -> frame_writes=10 from the cycle after frame_end; wr_slot on the frame_end cycle itself is counted in frame N.
